// File: rtl/rho_rotation_stage_pkg.sv
// Shared constants for the lane-rotation stage: geometry, FSM encodings and the
// per-lane rotation offsets R[i], indexed by bit i = 5*y + x.
package rho_rotation_stage_pkg;

   localparam int unsigned W     = 25;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned CNT_W = 6;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [W-1:0]     slice_t;
   typedef logic [1:0]       state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FILL  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   localparam cnt_t R_OFFSET [W] = '{
      6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
      6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
      6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
      6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
      6'd18, 6'd2,  6'd61, 6'd56, 6'd14
   };

   // Source slice for lane bit i of output slice z; CNT_W-bit arithmetic wraps mod DEPTH.
   function automatic cnt_t src_slice(input cnt_t z, input int unsigned i);
      return z - R_OFFSET[i];
   endfunction

endpackage

// File: rtl/rho_rotation_stage_if.sv
// Streaming bus of the lane-rotation stage: start/status plus valid/ready
// input and output slice channels.
interface rho_rotation_stage_if;
   import rho_rotation_stage_pkg::*;

   logic   start;
   logic   in_valid;
   logic   in_ready;
   slice_t in_data;
   logic   out_valid;
   logic   out_ready;
   slice_t out_data;
   logic   busy;
   logic   done;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, busy, done
   );

endinterface

// File: rtl/rho_rotation_stage_slice_buffer.sv
// One full state of DEPTH slices; the whole array is exposed so every lane bit
// can pick its own rotated source slice in parallel.
module rho_rotation_stage_slice_buffer
   import rho_rotation_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    we_i,
   input  cnt_t                    waddr_i,
   input  slice_t                  wdata_i,
   output logic [DEPTH-1:0][W-1:0] mem_o
);

   logic [DEPTH-1:0][W-1:0] mem_q;

   // Contents are don't-care until fully written, so no reset on the array.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign mem_o = mem_q;

endmodule

// File: rtl/rho_rotation_stage.sv
// Lane-rotation stage: buffers 64 slices, then re-emits them with each lane
// rotated along z by its fixed offset. FILL and DRAIN never overlap.
module rho_rotation_stage
   import rho_rotation_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   rho_rotation_stage_if.slave  bus
);

   state_t state_q, state_d;
   cnt_t   wr_cnt_q, wr_cnt_d;
   cnt_t   rd_cnt_q, rd_cnt_d;
   logic   done_q, done_d;

   logic                    wr_en;
   logic                    rd_en;
   logic [DEPTH-1:0][W-1:0] mem;
   slice_t                  rot_data;

   rho_rotation_stage_slice_buffer u_buf (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_cnt_q),
      .wdata_i (bus.in_data),
      .mem_o   (mem)
   );

   assign wr_en = (state_q == ST_FILL) && bus.in_valid;
   assign rd_en = (state_q == ST_DRAIN) && bus.out_ready;

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // done is raised as the FSM lands in IDLE; a start in that cycle is dropped.
            if (bus.start && !done_q) begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (wr_en) begin
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == cnt_t'(DEPTH - 1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (rd_en) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == cnt_t'(DEPTH - 1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      rot_data = '0;
      for (int unsigned i = 0; i < W; i++) begin
         rot_data[i] = mem[src_slice(rd_cnt_q, i)][i];
      end
   end

   assign bus.in_ready  = (state_q == ST_FILL);
   assign bus.out_valid = (state_q == ST_DRAIN);
   assign bus.out_data  = (state_q == ST_DRAIN) ? rot_data : '0;
   assign bus.busy      = (state_q == ST_FILL) || (state_q == ST_DRAIN);
   assign bus.done      = done_q;

endmodule
